lsu_mem_if: RTL and testbench
=============================

Name: lsu_mem_if

Overview:
- Load/store unit sitting between the pipeline MEM stage and the data-memory bus.
- Consumes the Load/Store access codes produced by the instruction decoder and performs the actual memory transaction: byte-enable generation, write-lane steering, bus handshake, and load sign/zero extension.
- Stalls the pipeline via `ls_ready` while a transaction is outstanding.

Parameters:
- `XLEN`, 32, data and address width (only 32 supported).
- `ADDR_W`, 32, bus address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `ls_valid` in 1: MEM-stage access request.
- `ls_is_store` in 1: 1 = store, 0 = load.
- `ls_store` in 2: 00 word, 01 half, 10 byte, 11 invalid.
- `ls_load` in 3: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu, 101–111 invalid.
- `ls_addr` in 32: effective byte address.
- `ls_wdata` in 32: store data (low bits significant).
- `ls_ready` out 1: high = can accept a request; low = stall.
- `ls_done` out 1: one-cycle completion pulse.
- `ls_rdata` out 32: extended load result, valid while `ls_done`=1.
- `ls_misalign` out 1: pulses with `ls_done` on a misaligned access that was not performed.
- `mem_req` out 1: bus request, held until ack.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: word-aligned address (bits[1:0]=00).
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-steered write data.
- `mem_ack` in 1: bus accepts/completes the beat this cycle.
- `mem_rdata` in 32: read data, valid with `mem_ack`.

Behaviour:
- **Reset:** async reset clears every output and register to 0 (`ls_ready`=1 is the only exception, it resets to 1); FSM goes to IDLE. Assertion mid-transaction drops `mem_req` immediately and discards the access, with no `ls_done`.
- **FSM states:** IDLE, BEAT1, BEAT2, DONE.
- **IDLE:** `ls_ready`=1. `ls_valid`=1 accepts the request and registers all inputs; the next state is chosen as follows:
  - Invalid code (`ls_store`=11 on a store, `ls_load`>100 on a load): go to DONE, no bus access, `ls_rdata`=0.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠00) and macro off: go to DONE with `ls_misalign`=1, no bus access.
  - Otherwise: go to BEAT1.
- **BEAT1:**
  - `mem_req`=1, `mem_addr`=addr&~3.
  - Byte enables: `mem_be` = byte: 0001<<a[1:0]; half: 0011<<a[1:0]; word: 1111.
  - Write data: `mem_wdata` = `ls_wdata`<<(8·a[1:0]).
  - All `mem_*` outputs are registered and stay stable until `mem_ack`.
  - On `mem_ack`: latch `mem_rdata`, then go to BEAT2 if split, else DONE.
- **BEAT2:** split accesses only (see Optional Feature).
- **DONE:**
  - `ls_done`=1 for exactly one cycle; `ls_rdata` = `mem_rdata` shifted right by 8·a[1:0], then extended.
  - Extension: lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw passes through.
  - Returns to IDLE. `ls_ready` is 0 throughout BEAT1/BEAT2/DONE.
- **Stores:** `ls_rdata`=0 at `ls_done`.
- **Latency:** accept at cycle N, `mem_req` from N+1. If `mem_ack` arrives at cycle M, `ls_done` occurs at M+1. Minimum accept-to-done is 2 cycles; an unperformed access (invalid/misaligned) completes in 1.
- **Busy/ack corner cases:** `ls_valid` while `ls_ready`=0 is ignored. `mem_ack` while `mem_req`=0 is ignored.
- **No reordering:** one outstanding access at a time.

Optional Feature:
- Macro: `LSU_MISALIGN_SPLIT_EN`.
- **Defined:** misaligned half/word accesses are split into two aligned beats, with offset k=a[1:0]:
  - BEAT1: addr&~3, `mem_be`=(1111 or 0011)<<k truncated to 4 bits, `mem_wdata`=`ls_wdata`<<8k.
  - BEAT2: (addr&~3)+4, wrapping modulo 2^32; `mem_be` = remaining lanes; `mem_wdata`=`ls_wdata`>>(32−8k).
  - Load result = {beat2, beat1}>>8k, then extended.
  - `ls_misalign` is never asserted.
- **Undefined:** misaligned accesses are not performed; `ls_misalign` pulses as described above.

Decomposition:
- Shared package `lsu_pkg`:
  - Store codes: ST_W, ST_H, ST_B.
  - Load codes: LD_B, LD_H, LD_W, LD_BU, LD_HU.
  - FSM state encoding.
- One combinational sub-module, `lsu_lane_align`: byte-enable generation, write-lane shift, and read shift/extend. It is instantiated once; the FSM and registers stay in `lsu_mem_if`.

Test Plan:
- **Store byte with ack delay.** sb, addr 0x1003, wdata 0xAB; `mem_ack` 2 cycles late.
  - Required: `mem_addr` 0x1000, `be` 1000, `wdata` 0xAB000000 held stable until ack; `ls_done` the cycle after ack; `ls_ready` low throughout.
- **Load sign/zero extension.** lb addr 0x2001, `mem_rdata` 0x0000F100 → `ls_rdata` 0xFFFFFFF1. lbu same → 0x000000F1. lhu addr 0x2002, rdata 0x80000000 → 0x00008000.
- **Misaligned word, macro off.** lw addr 0x3002 → no `mem_req`; `ls_done` and `ls_misalign` at N+1; `ls_rdata` 0.
- **Misaligned split, macro on, with wrap.**
  - lw addr 0xFFFFFFFE: beats at 0xFFFFFFFC with be 1100, then 0x00000000 with be 0011.
  - rdata 0xBEEF0000 then 0x0000DEAD → `ls_rdata` 0xDEADBEEF.
- **Invalid code.** `ls_store`=11 → no bus activity; `ls_done` next cycle.
- **Reset mid-transaction.** Assert `rst_n`=0 while in BEAT1 → `mem_req` 0 immediately; after release `ls_ready`=1, no spurious `ls_done`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access codes, access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] ST_W   = 2'b00;
  localparam logic [1:0] ST_H   = 2'b01;
  localparam logic [1:0] ST_B   = 2'b10;
  localparam logic [1:0] ST_INV = 2'b11;

  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_W  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } acc_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StBeat1,
    StBeat2,
    StDone
  } lsu_state_e;

  // Invalid codes map to SzWord; they are rejected before any bus access.
  function automatic acc_size_e access_size(input logic       is_store,
                                            input logic [1:0] st,
                                            input logic [2:0] ld);
    acc_size_e sz;
    sz = SzWord;
    if (is_store) begin
      case (st)
        ST_H:    sz = SzHalf;
        ST_B:    sz = SzByte;
        default: sz = SzWord;
      endcase
    end else begin
      case (ld)
        LD_B, LD_BU: sz = SzByte;
        LD_H, LD_HU: sz = SzHalf;
        default:     sz = SzWord;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Pipeline-side request/response and data-memory bus signals of the load/store unit.
interface lsu_mem_if_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);

  logic              ls_valid;
  logic              ls_is_store;
  logic [1:0]        ls_store;
  logic [2:0]        ls_load;
  logic [ADDR_W-1:0] ls_addr;
  logic [XLEN-1:0]   ls_wdata;
  logic              ls_ready;
  logic              ls_done;
  logic [XLEN-1:0]   ls_rdata;
  logic              ls_misalign;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  // LSU view.
  modport slave (
    input  ls_valid, ls_is_store, ls_store, ls_load, ls_addr, ls_wdata, mem_ack, mem_rdata,
    output ls_ready, ls_done, ls_rdata, ls_misalign,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  // Environment view: pipeline plus memory.
  modport master (
    output ls_valid, ls_is_store, ls_store, ls_load, ls_addr, ls_wdata, mem_ack, mem_rdata,
    input  ls_ready, ls_done, ls_rdata, ls_misalign,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables, write-lane steering, read shift and extension.
// LSU_MISALIGN_SPLIT_EN: split boundary-crossing accesses into two beats instead of rejecting.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        i_is_store,
  input  logic [1:0]  i_store,
  input  logic [2:0]  i_load,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_lo,
  input  logic [31:0] i_rdata_hi,
  output logic [3:0]  o_be1,
  output logic [3:0]  o_be2,
  output logic [31:0] o_wdata1,
  output logic [31:0] o_wdata2,
  output logic [31:0] o_rdata,
  output logic        o_invalid,
  output logic        o_misalign,
  output logic        o_split
);

  acc_size_e   w_size;
  logic [3:0]  w_mask;
  logic [7:0]  w_be_wide;
  logic [63:0] w_wd_wide;
  logic [31:0] w_rd;
  logic [4:0]  w_shamt;
  logic        w_unaligned;

  always_comb begin
    w_size    = access_size(i_is_store, i_store, i_load);
    w_shamt   = {i_offset, 3'b000};
    o_invalid = i_is_store ? (i_store == ST_INV) : (i_load > LD_HU);

    unique case (w_size)
      SzByte:  w_mask = 4'b0001;
      SzHalf:  w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase

    // Upper halves of the wide vectors are the lanes that spill into the next word.
    w_be_wide = {4'b0000, w_mask} << i_offset;
    w_wd_wide = {32'h0, i_wdata} << w_shamt;
    w_rd      = 32'({i_rdata_hi, i_rdata_lo} >> w_shamt);

    o_be1    = w_be_wide[3:0];
    o_be2    = w_be_wide[7:4];
    o_wdata1 = w_wd_wide[31:0];
    o_wdata2 = w_wd_wide[63:32];

    w_unaligned = ((w_size == SzHalf) && i_offset[0]) ||
                  ((w_size == SzWord) && (i_offset != 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
    o_misalign = 1'b0;
    o_split    = w_unaligned && (w_be_wide[7:4] != 4'b0000);
`else
    o_misalign = w_unaligned;
    o_split    = 1'b0;
`endif

    o_rdata = 32'h0;
    if (!i_is_store && !o_invalid) begin
      case (i_load)
        LD_B:    o_rdata = {{24{w_rd[7]}}, w_rd[7:0]};
        LD_H:    o_rdata = {{16{w_rd[15]}}, w_rd[15:0]};
        LD_BU:   o_rdata = {24'h0, w_rd[7:0]};
        LD_HU:   o_rdata = {16'h0, w_rd[15:0]};
        default: o_rdata = w_rd;
      endcase
    end
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit between the MEM stage and the data-memory bus; one access in flight.
// LSU_MISALIGN_SPLIT_EN: misaligned accesses crossing a word become two bus beats.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_mem_if_if.slave  bus
);

  lsu_state_e        r_state, w_state_nxt;
  logic              r_is_store, w_is_store_nxt;
  logic [1:0]        r_store, w_store_nxt;
  logic [2:0]        r_load, w_load_nxt;
  logic [1:0]        r_offset, w_offset_nxt;
  logic [XLEN-1:0]   r_wdata, w_wdata_nxt;
  logic [31:0]       r_rdata_lo, w_rdata_lo_nxt;
  logic [XLEN-1:0]   r_rdata, w_rdata_nxt;
  logic              r_misalign, w_misalign_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [3:0]        r_mem_be, w_mem_be_nxt;
  logic [XLEN-1:0]   r_mem_wdata, w_mem_wdata_nxt;

  logic        w_idle;
  logic        w_al_is_store;
  logic [1:0]  w_al_store;
  logic [2:0]  w_al_load;
  logic [1:0]  w_al_offset;
  logic [31:0] w_al_wdata;
  logic [31:0] w_al_rdata_lo;
  logic [31:0] w_al_rdata_hi;
  logic [3:0]  w_be1, w_be2;
  logic [31:0] w_wdata1, w_wdata2;
  logic [31:0] w_rdata;
  logic        w_invalid, w_misalign, w_split;

  // In IDLE the aligner decodes the incoming request; afterwards the latched one.
  always_comb begin
    w_idle        = (r_state == StIdle);
    w_al_is_store = w_idle ? bus.ls_is_store   : r_is_store;
    w_al_store    = w_idle ? bus.ls_store      : r_store;
    w_al_load     = w_idle ? bus.ls_load       : r_load;
    w_al_offset   = w_idle ? bus.ls_addr[1:0]  : r_offset;
    w_al_wdata    = w_idle ? bus.ls_wdata      : r_wdata;
    w_al_rdata_lo = (r_state == StBeat2) ? r_rdata_lo    : bus.mem_rdata;
    w_al_rdata_hi = (r_state == StBeat2) ? bus.mem_rdata : 32'h0;
  end

  lsu_lane_align u_lane_align (
    .i_is_store (w_al_is_store),
    .i_store    (w_al_store),
    .i_load     (w_al_load),
    .i_offset   (w_al_offset),
    .i_wdata    (w_al_wdata),
    .i_rdata_lo (w_al_rdata_lo),
    .i_rdata_hi (w_al_rdata_hi),
    .o_be1      (w_be1),
    .o_be2      (w_be2),
    .o_wdata1   (w_wdata1),
    .o_wdata2   (w_wdata2),
    .o_rdata    (w_rdata),
    .o_invalid  (w_invalid),
    .o_misalign (w_misalign),
    .o_split    (w_split)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_is_store_nxt  = r_is_store;
    w_store_nxt     = r_store;
    w_load_nxt      = r_load;
    w_offset_nxt    = r_offset;
    w_wdata_nxt     = r_wdata;
    w_rdata_lo_nxt  = r_rdata_lo;
    w_rdata_nxt     = r_rdata;
    w_misalign_nxt  = r_misalign;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_be_nxt    = r_mem_be;
    w_mem_wdata_nxt = r_mem_wdata;

    unique case (r_state)
      StIdle: begin
        if (bus.ls_valid) begin
          w_is_store_nxt = bus.ls_is_store;
          w_store_nxt    = bus.ls_store;
          w_load_nxt     = bus.ls_load;
          w_offset_nxt   = bus.ls_addr[1:0];
          w_wdata_nxt    = bus.ls_wdata;
          w_rdata_nxt    = '0;
          w_misalign_nxt = 1'b0;
          if (w_invalid) begin
            w_state_nxt = StDone;
          end else if (w_misalign) begin
            w_state_nxt    = StDone;
            w_misalign_nxt = 1'b1;
          end else begin
            w_state_nxt     = StBeat1;
            w_mem_we_nxt    = bus.ls_is_store;
            w_mem_addr_nxt  = {bus.ls_addr[ADDR_W-1:2], 2'b00};
            w_mem_be_nxt    = w_be1;
            w_mem_wdata_nxt = w_wdata1;
          end
        end
      end
      StBeat1: begin
        if (bus.mem_ack) begin
          if (w_split) begin
            w_state_nxt     = StBeat2;
            w_rdata_lo_nxt  = bus.mem_rdata;
            w_mem_addr_nxt  = r_mem_addr + ADDR_W'(4);
            w_mem_be_nxt    = w_be2;
            w_mem_wdata_nxt = w_wdata2;
          end else begin
            w_state_nxt = StDone;
            w_rdata_nxt = w_rdata;
          end
        end
      end
      StBeat2: begin
        if (bus.mem_ack) begin
          w_state_nxt = StDone;
          w_rdata_nxt = w_rdata;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_is_store  <= 1'b0;
      r_store     <= 2'b00;
      r_load      <= 3'b000;
      r_offset    <= 2'b00;
      r_wdata     <= '0;
      r_rdata_lo  <= '0;
      r_rdata     <= '0;
      r_misalign  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_is_store  <= w_is_store_nxt;
      r_store     <= w_store_nxt;
      r_load      <= w_load_nxt;
      r_offset    <= w_offset_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rdata_lo  <= w_rdata_lo_nxt;
      r_rdata     <= w_rdata_nxt;
      r_misalign  <= w_misalign_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  // Handshake outputs decode the state register so reset drops them immediately.
  assign bus.ls_ready    = (r_state == StIdle);
  assign bus.ls_done     = (r_state == StDone);
  assign bus.ls_misalign = (r_state == StDone) && r_misalign;
  assign bus.ls_rdata    = r_rdata;
  assign bus.mem_req     = (r_state == StBeat1) || (r_state == StBeat2);
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_be      = r_mem_be;
  assign bus.mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed self-checking bench for lsu_mem_if; the split test runs when LSU_MISALIGN_SPLIT_EN is set.
module tb_lsu_mem_if;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lsu_mem_if_if #(.XLEN(32), .ADDR_W(32)) u_if ();

  lsu_mem_if #(.XLEN(32), .ADDR_W(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single edge, then withdraws it.
  task automatic req(input logic is_st, input logic [1:0] st, input logic [2:0] ld,
                     input logic [31:0] addr, input logic [31:0] wd);
    u_if.ls_valid    = 1'b1;
    u_if.ls_is_store = is_st;
    u_if.ls_store    = st;
    u_if.ls_load     = ld;
    u_if.ls_addr     = addr;
    u_if.ls_wdata    = wd;
    tick();
    u_if.ls_valid = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rd);
    u_if.mem_ack   = 1'b1;
    u_if.mem_rdata = rd;
    tick();
    u_if.mem_ack   = 1'b0;
    u_if.mem_rdata = 32'h0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] ld, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] rd,
                           input logic [31:0] exp);
    req(1'b0, 2'b00, ld, addr, 32'h0);
    chk({tag, "_req"}, u_if.mem_req, 1);
    chk({tag, "_we"}, u_if.mem_we, 0);
    chk({tag, "_addr"}, u_if.mem_addr, {addr[31:2], 2'b00});
    chk({tag, "_be"}, u_if.mem_be, be);
    ack(rd);
    chk({tag, "_done"}, u_if.ls_done, 1);
    chk({tag, "_rdata"}, u_if.ls_rdata, exp);
    tick();
    chk({tag, "_ready"}, u_if.ls_ready, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n            = 1'b0;
    u_if.ls_valid    = 1'b0;
    u_if.ls_is_store = 1'b0;
    u_if.ls_store    = 2'b00;
    u_if.ls_load     = 3'b000;
    u_if.ls_addr     = 32'h0;
    u_if.ls_wdata    = 32'h0;
    u_if.mem_ack     = 1'b0;
    u_if.mem_rdata   = 32'h0;

    #3;
    chk("rst_ready", u_if.ls_ready, 1);
    chk("rst_done", u_if.ls_done, 0);
    chk("rst_req", u_if.mem_req, 0);
    chk("rst_rdata", u_if.ls_rdata, 0);
    chk("rst_misalign", u_if.ls_misalign, 0);
    #19 rst_n = 1'b1;
    tick();

    // sb 0x1003, ack two cycles late
    req(1'b1, lsu_pkg::ST_B, 3'b000, 32'h0000_1003, 32'h0000_00AB);
    for (int i = 0; i < 2; i++) begin
      chk("sb_req", u_if.mem_req, 1);
      chk("sb_we", u_if.mem_we, 1);
      chk("sb_addr", u_if.mem_addr, 32'h0000_1000);
      chk("sb_be", u_if.mem_be, 4'b1000);
      chk("sb_wdata", u_if.mem_wdata, 32'hAB00_0000);
      chk("sb_ready", u_if.ls_ready, 0);
      chk("sb_nodone", u_if.ls_done, 0);
      tick();
    end
    chk("sb_be_late", u_if.mem_be, 4'b1000);
    ack(32'hFFFF_FFFF);
    chk("sb_done", u_if.ls_done, 1);
    chk("sb_rdata0", u_if.ls_rdata, 0);
    chk("sb_req_off", u_if.mem_req, 0);
    chk("sb_ready_done", u_if.ls_ready, 0);
    tick();
    chk("sb_done_pulse", u_if.ls_done, 0);
    chk("sb_ready_back", u_if.ls_ready, 1);

    load_case("lb", lsu_pkg::LD_B, 32'h0000_2001, 4'b0010, 32'h0000_F100, 32'hFFFF_FFF1);
    load_case("lbu", lsu_pkg::LD_BU, 32'h0000_2001, 4'b0010, 32'h0000_F100, 32'h0000_00F1);
    load_case("lhu", lsu_pkg::LD_HU, 32'h0000_2002, 4'b1100, 32'h8000_0000, 32'h0000_8000);
    load_case("lh", lsu_pkg::LD_H, 32'h0000_2006, 4'b1100, 32'h8001_1234, 32'hFFFF_8001);

    // lw with a second request held during the beat: it must be ignored
    req(1'b0, 2'b00, lsu_pkg::LD_W, 32'h0000_2004, 32'h0);
    u_if.ls_valid = 1'b1;
    u_if.ls_addr  = 32'h0000_5000;
    tick();
    chk("busy_addr", u_if.mem_addr, 32'h0000_2004);
    u_if.ls_valid = 1'b0;
    ack(32'h1234_5678);
    chk("lw_rdata", u_if.ls_rdata, 32'h1234_5678);
    tick();
    chk("busy_noreq", u_if.mem_req, 0);

    // Stray ack while idle
    u_if.mem_ack = 1'b1;
    tick();
    u_if.mem_ack = 1'b0;
    chk("stray_done", u_if.ls_done, 0);
    chk("stray_req", u_if.mem_req, 0);

`ifdef LSU_MISALIGN_SPLIT_EN
    req(1'b0, 2'b00, lsu_pkg::LD_W, 32'hFFFF_FFFE, 32'h0);
    chk("sp_addr1", u_if.mem_addr, 32'hFFFF_FFFC);
    chk("sp_be1", u_if.mem_be, 4'b1100);
    ack(32'hBEEF_0000);
    chk("sp_req2", u_if.mem_req, 1);
    chk("sp_addr2", u_if.mem_addr, 32'h0000_0000);
    chk("sp_be2", u_if.mem_be, 4'b0011);
    ack(32'h0000_DEAD);
    chk("sp_done", u_if.ls_done, 1);
    chk("sp_rdata", u_if.ls_rdata, 32'hDEAD_BEEF);
    chk("sp_misalign", u_if.ls_misalign, 0);
    tick();
`else
    req(1'b0, 2'b00, lsu_pkg::LD_W, 32'h0000_3002, 32'h0);
    chk("mis_req", u_if.mem_req, 0);
    chk("mis_done", u_if.ls_done, 1);
    chk("mis_flag", u_if.ls_misalign, 1);
    chk("mis_rdata", u_if.ls_rdata, 0);
    tick();
    chk("mis_flag_pulse", u_if.ls_misalign, 0);
    req(1'b0, 2'b00, lsu_pkg::LD_H, 32'h0000_3001, 32'h0);
    chk("mish_req", u_if.mem_req, 0);
    chk("mish_flag", u_if.ls_misalign, 1);
    tick();
`endif

    // Invalid codes complete without bus activity
    req(1'b1, lsu_pkg::ST_INV, 3'b000, 32'h0000_4000, 32'h1);
    chk("inv_st_req", u_if.mem_req, 0);
    chk("inv_st_done", u_if.ls_done, 1);
    chk("inv_st_mis", u_if.ls_misalign, 0);
    tick();
    req(1'b0, 2'b00, 3'b101, 32'h0000_4000, 32'h0);
    chk("inv_ld_req", u_if.mem_req, 0);
    chk("inv_ld_done", u_if.ls_done, 1);
    chk("inv_ld_rdata", u_if.ls_rdata, 0);
    tick();

    // Reset during BEAT1
    req(1'b0, 2'b00, lsu_pkg::LD_W, 32'h0000_6000, 32'h0);
    chk("rm_req_before", u_if.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_req_async", u_if.mem_req, 0);
    chk("rm_ready_async", u_if.ls_ready, 1);
    #3 rst_n = 1'b1;
    u_if.mem_ack = 1'b1;
    tick();
    u_if.mem_ack = 1'b0;
    chk("rm_nodone1", u_if.ls_done, 0);
    tick();
    chk("rm_nodone2", u_if.ls_done, 0);
    chk("rm_ready", u_if.ls_ready, 1);
    chk("rm_noreq", u_if.mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
